hazard_scoreboard: RTL and testbench

//  Parametrised hazard unit for the pipelined processor. Replaces the ad-hoc stall compare and

---
 rtl/hazard_pkg.sv | 6 +
 rtl/hazard_fwd_match.sv | 29 ++
 rtl/hazard_scoreboard.sv | 101 ++++++++++
 tb/tb_hazard_scoreboard.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and types for the hazard scoreboard.
package hazard_pkg;
  localparam int REG_ADDR_W_DEF = 3;
  localparam int FWD_REGFILE = 0;
  typedef enum logic [1:0] {UPD_HOLD, UPD_BUBBLE, UPD_SHIFT} upd_e;
endpackage

// File: rtl/hazard_fwd_match.sv
// hazard_fwd_match: nearest-producer forwarding select for one EX operand.
module hazard_fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_STAGE = 2,
  parameter int FWD_SEL_W = $clog2(NUM_STAGES)
) (
  input  logic                                   rs_en,
  input  logic [REG_ADDR_W-1:0]                  rs,
  input  logic [NUM_STAGES-2:0]                  p_valid,
  input  logic [NUM_STAGES-2:0]                  p_wr,
  input  logic [NUM_STAGES-2:0]                  p_load,
  input  logic [(NUM_STAGES-1)*REG_ADDR_W-1:0]   p_rd,
  output logic [FWD_SEL_W-1:0]                   sel
);
  logic [NUM_STAGES-2:0] hit;
  for (genvar g = 1; g < NUM_STAGES; g++) begin : g_hit
    assign hit[g-1] = p_valid[g-1] && p_wr[g-1] && p_rd[(g-1)*REG_ADDR_W +: REG_ADDR_W] == rs &&
                      !(p_load[g-1] && g < LOAD_STAGE);
  end
  // Scan far-to-near so the nearest matching slot is assigned last and wins.
  always_comb begin
    sel = FWD_SEL_W'(FWD_REGFILE);
    for (int k = NUM_STAGES - 1; k >= 1; k--)
      sel = (rs_en && hit[k-1]) ? FWD_SEL_W'(k) : sel;
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination scoreboard giving load-use stall and EX forwarding selects.
// Optional stall/flush statistics counters when HAZARD_STATS_EN is defined.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_STAGE = 2,
  localparam int FWD_SEL_W = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold_i,
  input  logic                  flush_i,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic                  id_rs1_used,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wr,
  input  logic                  id_load,
  output logic                  stall,
  output logic [FWD_SEL_W-1:0]  fwd_sel1,
  output logic [FWD_SEL_W-1:0]  fwd_sel2,
  output logic                  ex_valid
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           flush_cnt
`endif
);
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
    logic                  load;
  } slot_t;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic                  rs1_used;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs2_used;
  } src_t;
  slot_t slots [NUM_STAGES];
  src_t  src;
  upd_e  upd;
  assign upd = hold_i ? UPD_HOLD : (flush_i || stall) ? UPD_BUBBLE : UPD_SHIFT;
  // Source operands only matter while the instruction sits in EX, so they are kept for slot 0 only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_STAGES; k++) slots[k] <= '0;
      src <= '0;
    end else if (upd != UPD_HOLD) begin
      slots[0] <= upd == UPD_BUBBLE ? '0 :
                  slot_t'{valid: id_valid, rd: id_rd, wr: id_wr, load: id_load};
      for (int k = 1; k < NUM_STAGES; k++) slots[k] <= slots[k-1];
      src <= upd == UPD_BUBBLE ? '0 :
             src_t'{rs1: id_rs1, rs1_used: id_rs1_used, rs2: id_rs2, rs2_used: id_rs2_used};
    end
  end
  always_comb begin
    stall = 1'b0;
    for (int k = 0; k < LOAD_STAGE - 1; k++)
      stall = stall || (slots[k].valid && slots[k].wr && slots[k].load &&
              ((id_rs1_used && slots[k].rd == id_rs1) || (id_rs2_used && slots[k].rd == id_rs2)));
    stall = stall && id_valid && !flush_i;
  end
  assign ex_valid = slots[0].valid;
  logic [NUM_STAGES-2:0]                 p_valid, p_wr, p_load;
  logic [(NUM_STAGES-1)*REG_ADDR_W-1:0]  p_rd;
  for (genvar g = 1; g < NUM_STAGES; g++) begin : g_pack
    assign p_valid[g-1] = slots[g].valid;
    assign p_wr[g-1]    = slots[g].wr;
    assign p_load[g-1]  = slots[g].load;
    assign p_rd[(g-1)*REG_ADDR_W +: REG_ADDR_W] = slots[g].rd;
  end
  hazard_fwd_match #(
    .REG_ADDR_W(REG_ADDR_W), .NUM_STAGES(NUM_STAGES), .LOAD_STAGE(LOAD_STAGE), .FWD_SEL_W(FWD_SEL_W)
  ) u_fwd1 (
    .rs_en(src.rs1_used && slots[0].valid), .rs(src.rs1),
    .p_valid(p_valid), .p_wr(p_wr), .p_load(p_load), .p_rd(p_rd), .sel(fwd_sel1)
  );
  hazard_fwd_match #(
    .REG_ADDR_W(REG_ADDR_W), .NUM_STAGES(NUM_STAGES), .LOAD_STAGE(LOAD_STAGE), .FWD_SEL_W(FWD_SEL_W)
  ) u_fwd2 (
    .rs_en(src.rs2_used && slots[0].valid), .rs(src.rs2),
    .p_valid(p_valid), .p_wr(p_wr), .p_load(p_load), .p_rd(p_rd), .sel(fwd_sel2)
  );
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!hold_i) begin
      stall_cnt <= (stall && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
      flush_cnt <= (flush_i && flush_cnt != 16'hFFFF) ? flush_cnt + 16'd1 : flush_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed stimulus, queue-based pipeline model checked every cycle.
module tb_hazard_scoreboard;
  localparam int NS = 3;
  localparam int LS = 2;
  logic clk = 1'b0, rst = 1'b1, hold_i = 1'b0, flush_i = 1'b0;
  logic id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_wr = 1'b0, id_load = 1'b0;
  logic [2:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic stall, ex_valid;
  logic [1:0] fwd_sel1, fwd_sel2;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif
  int checks = 0, errors = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .stall(stall),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .ex_valid(ex_valid)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: queue of in-flight instructions, index 0 = EX.
  typedef struct {bit v; int rd; bit wr; bit ld; int rs1; bit u1; int rs2; bit u2;} rec_t;
  rec_t pipe[$];
  bit model_ok = 0;
  int m_stalls = 0, m_flushes = 0;

  function automatic bit exp_stall();
    if (!id_valid || flush_i) return 0;
    for (int k = 0; k < LS - 1; k++)
      if (pipe[k].v && pipe[k].wr && pipe[k].ld &&
          ((id_rs1_used && pipe[k].rd == int'(id_rs1)) || (id_rs2_used && pipe[k].rd == int'(id_rs2))))
        return 1;
    return 0;
  endfunction

  function automatic int exp_fwd(int rs, bit used);
    if (!used || !pipe[0].v) return 0;
    for (int k = 1; k < NS; k++)
      if (pipe[k].v && pipe[k].wr && pipe[k].rd == rs && !(pipe[k].ld && k < LS)) return k;
    return 0;
  endfunction

  always @(posedge clk) begin
    rec_t r, bub;
    bit s;
    bub = '{default: 0};
    if (rst) begin
      pipe = {};
      repeat (NS) pipe.push_back(bub);
      m_stalls = 0;
      m_flushes = 0;
      model_ok = 1;
    end else if (model_ok && !hold_i) begin
      s = exp_stall();
      if (s && m_stalls < 65535) m_stalls++;
      if (flush_i && m_flushes < 65535) m_flushes++;
      r = '{v: id_valid, rd: int'(id_rd), wr: id_wr, ld: id_load,
            rs1: int'(id_rs1), u1: id_rs1_used, rs2: int'(id_rs2), u2: id_rs2_used};
      pipe.push_front((flush_i || s) ? bub : r);
      void'(pipe.pop_back());
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_stall", stall, exp_stall());
      chk("m_ex_valid", ex_valid, pipe[0].v);
      chk("m_fwd1", fwd_sel1, exp_fwd(pipe[0].rs1, pipe[0].u1));
      chk("m_fwd2", fwd_sel2, exp_fwd(pipe[0].rs2, pipe[0].u2));
`ifdef HAZARD_STATS_EN
      chk("m_stall_cnt", stall_cnt, m_stalls);
      chk("m_flush_cnt", flush_cnt, m_flushes);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(bit v, int rd, bit wr, bit ld, int rs1, bit u1, int rs2, bit u2);
    id_valid = v; id_rd = 3'(rd); id_wr = wr; id_load = ld;
    id_rs1 = 3'(rs1); id_rs1_used = u1; id_rs2 = 3'(rs2); id_rs2_used = u2;
  endtask

  task automatic idle();
    dec(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    idle();
    repeat (NS) cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_stall", stall, 0); chk("rst_exv", ex_valid, 0);
    chk("rst_fwd1", fwd_sel1, 0); chk("rst_fwd2", fwd_sel2, 0);
    // Load-use: LDD R3 ; ADD R1,R3,R2
    dec(1, 3, 1, 1, 0, 0, 0, 0); #1 chk("t1_no_stall", stall, 0); cyc();
    dec(1, 1, 1, 0, 3, 1, 2, 1); #1 chk("t1_stall", stall, 1); chk("t1_exv", ex_valid, 1); cyc();
    #1 chk("t1_stall_once", stall, 0); chk("t1_bubble", ex_valid, 0); cyc();
    idle(); #1 chk("t1_fwd1", fwd_sel1, 2); chk("t1_fwd2", fwd_sel2, 0); chk("t1_exv2", ex_valid, 1);
    drain();
    // ALU chain: ADD R2 ; SUB R4,R2,R2
    dec(1, 2, 1, 0, 0, 1, 1, 1); cyc();
    dec(1, 4, 1, 0, 2, 1, 2, 1); #1 chk("t2_no_stall", stall, 0); cyc();
    idle(); #1 chk("t2_fwd1", fwd_sel1, 1); chk("t2_fwd2", fwd_sel2, 1);
    drain();
    // Multi-match: nearest producer wins
    dec(1, 5, 1, 0, 0, 0, 0, 0); cyc();
    dec(1, 5, 1, 0, 0, 0, 0, 0); cyc();
    dec(1, 6, 1, 0, 5, 1, 0, 0); cyc();
    idle(); #1 chk("t3_nearest", fwd_sel1, 1);
    drain();
    // Nearer instruction does not write: farther producer forwards
    dec(1, 5, 1, 0, 0, 0, 0, 0); cyc();
    dec(1, 5, 0, 0, 0, 0, 0, 0); cyc();
    dec(1, 6, 1, 0, 5, 1, 0, 0); cyc();
    idle(); #1 chk("t3_skip_nowr", fwd_sel1, 2);
    drain();
    // R0 is an ordinary register; unused source never forwards
    dec(1, 0, 1, 0, 0, 0, 0, 0); cyc();
    dec(1, 1, 1, 0, 0, 0, 0, 1); cyc();
    idle(); #1 chk("t3_r0_fwd2", fwd_sel2, 1); chk("t3_unused_fwd1", fwd_sel1, 0);
    drain();
    // Load with one instruction between: no stall, forwarded from WB
    dec(1, 6, 1, 1, 0, 0, 0, 0); cyc();
    dec(1, 7, 1, 0, 6, 0, 1, 1); #1 chk("t3_unused_nostall", stall, 0); cyc();
    dec(1, 1, 1, 0, 6, 1, 0, 0); #1 chk("t3_gap_nostall", stall, 0); cyc();
    idle(); #1 chk("t3_gap_fwd", fwd_sel1, 2);
    drain();
    // Flush kills a load-use decode
    dec(1, 3, 1, 1, 0, 0, 0, 0); cyc();
    dec(1, 1, 1, 0, 0, 0, 3, 1); #1 chk("t4_pre_stall", stall, 1);
    flush_i = 1'b1; #1 chk("t4_flush_nostall", stall, 0); cyc();
    flush_i = 1'b0; idle(); #1 chk("t4_bubble", ex_valid, 0);
    drain();
    // Hold for 3 cycles mid-stream
    dec(1, 1, 1, 0, 0, 0, 0, 0); cyc();
    dec(1, 2, 1, 0, 1, 1, 0, 0); cyc();
    dec(1, 3, 1, 0, 0, 0, 2, 1); hold_i = 1'b1;
    #1 chk("t5_pre_fwd1", fwd_sel1, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_hold_exv", ex_valid, 1); chk("t5_hold_fwd1", fwd_sel1, 1); chk("t5_hold_fwd2", fwd_sel2, 0);
    end
    hold_i = 1'b0; cyc();
    idle(); #1 chk("t5_resume_fwd2", fwd_sel2, 1); chk("t5_resume_fwd1", fwd_sel1, 0); cyc();
    #1 chk("t5_resume_exv", ex_valid, 0);
    drain();
    // Stall still visible under hold, acted on only after release
    dec(1, 3, 1, 1, 0, 0, 0, 0); cyc();
    dec(1, 1, 1, 0, 3, 1, 0, 0); hold_i = 1'b1; #1 chk("t5_hold_stall", stall, 1); cyc();
    chk("t5_hold_stall2", stall, 1); hold_i = 1'b0; cyc();
    #1 chk("t5_after_stall", stall, 0); chk("t5_after_exv", ex_valid, 0);
    drain();
    // Reset in the middle of a stall
    dec(1, 3, 1, 1, 0, 0, 0, 0); cyc();
    dec(1, 1, 1, 0, 3, 1, 0, 0); #1 chk("t6_stall", stall, 1);
    rst = 1'b1; cyc();
    #1 chk("t6_rst_stall", stall, 0); chk("t6_rst_exv", ex_valid, 0);
    chk("t6_rst_fwd1", fwd_sel1, 0); chk("t6_rst_fwd2", fwd_sel2, 0);
    rst = 1'b0; idle(); cyc();
    // Four load-use stalls and two flushes
    for (int i = 0; i < 4; i++) begin
      dec(1, 3, 1, 1, 0, 0, 0, 0); cyc();
      dec(1, 4, 1, 0, 3, 1, 0, 0); cyc();
      cyc();
      idle();
    end
    flush_i = 1'b1; cyc(); cyc();
    flush_i = 1'b0; #1;
`ifdef HAZARD_STATS_EN
    chk("t6_stall_cnt", stall_cnt, 4); chk("t6_flush_cnt", flush_cnt, 2);
    rst = 1'b1; cyc();
    rst = 1'b0; #1;
    chk("t6_rst_stall_cnt", stall_cnt, 0); chk("t6_rst_flush_cnt", flush_cnt, 0);
`endif
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
